// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with an iterative multiply/divide engine.
//   Simple ops (add/sub/slt/logic/shift) are staged once, so their result
//   appears one edge after the accept edge. MULT/DIV run WIDTH iterations of
//   an unsigned shift-add / restoring-divide core on operand magnitudes. The
//   sign is fixed up in DONE, and the result then goes through the same
//   output stage.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   in_valid / in_ready  issue handshake (ready only in IDLE)
//   alu_ctrl, a, b, shamt  operation code and operands
//   result, zero         registered result and (result == 0)
//   out_valid            one-cycle completion pulse
//   hi, lo               HI/LO registers written by MULT/DIV only
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_MULT = 4'b1101;
    localparam logic [3:0] OP_DIV  = 4'b1011;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // MUL: product high / DIV: remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // MUL: multiplier->low / DIV: dividend->quotient
    logic [WIDTH-1:0] mcand_q, mcand_d;     // MUL: multiplicand / DIV: divisor
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             is_div_q, is_div_d;
    logic             divz_q, divz_d;
    logic             stg_vld_q, stg_vld_d;
    logic             stg_hilo_q, stg_hilo_d;
    logic [WIDTH-1:0] stg_res_q, stg_res_d;
    logic [WIDTH-1:0] stg_hi_q, stg_hi_d;
    logic [WIDTH-1:0] stg_lo_q, stg_lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH-1:0] simple_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [W2-1:0]    prod;
    logic [W2-1:0]    prod_s;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             accept;

    // Single-cycle operations; unknown codes behave as NOP.
    always_comb begin
        simple_res = '0;
        case (alu_ctrl)
            4'b0000:          simple_res = a + b;
            4'b0100, 4'b0110: simple_res = a - b;
            4'b0101:          simple_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            4'b1000:          simple_res = a & b;
            4'b1010:          simple_res = a | b;
            4'b1100:          simple_res = ~(a | b);
            4'b0010:          simple_res = b << shamt;
            4'b0011:          simple_res = b >> shamt;
            default:          simple_res = '0;
        endcase
    end

    // Next-state, datapath and output-stage logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        mcand_d     = mcand_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        is_div_d    = is_div_q;
        divz_d      = divz_q;
        stg_vld_d   = 1'b0;
        stg_hilo_d  = stg_hilo_q;
        stg_res_d   = stg_res_q;
        stg_hi_d    = stg_hi_q;
        stg_lo_d    = stg_lo_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;

        accept  = in_valid && in_ready_q;
        mag_a   = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
        mag_b   = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, mcand_q};
        prod    = {acc_hi_q, acc_lo_q};
        prod_s  = neg_lo_q ? (W2'(0) - prod) : prod;

        // Output stage: publish whatever completed on the previous edge.
        if (stg_vld_q) begin
            result_d    = stg_res_q;
            zero_d      = (stg_res_q == '0);
            out_valid_d = 1'b1;
            if (stg_hilo_q) begin
                hi_d = stg_hi_q;
                lo_d = stg_lo_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
                    divz_d   = (b == '0);
                    if (alu_ctrl == OP_MULT) begin
                        acc_lo_d = mag_b;
                        mcand_d  = mag_a;
                        neg_hi_d = a[WIDTH-1] ^ b[WIDTH-1];
                        is_div_d = 1'b0;
                        state_d  = S_MUL;
                    end else if (alu_ctrl == OP_DIV) begin
                        acc_lo_d = mag_a;
                        mcand_d  = mag_b;
                        neg_hi_d = a[WIDTH-1];
                        is_div_d = 1'b1;
                        state_d  = S_DIV;
                    end else begin
                        stg_vld_d  = 1'b1;
                        stg_hilo_d = 1'b0;
                        stg_res_d  = simple_res;
                    end
                end
            end
            S_MUL: begin
                // Add-then-shift-right of {carry, hi, lo}.
                acc_hi_d = mul_sum[WIDTH:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_DONE;
            end
            S_DIV: begin
                // Restoring step: keep the subtraction only when it stays non-negative.
                if (!trial[WIDTH]) begin
                    acc_hi_d = trial[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = rem_sh[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                stg_vld_d  = 1'b1;
                stg_hilo_d = 1'b1;
                if (is_div_q) begin
                    // Divide by zero: the core leaves |a| as remainder, so hi == a after sign fix.
                    stg_lo_d = divz_q ? '1 : (neg_lo_q ? (WIDTH'(0) - acc_lo_q) : acc_lo_q);
                    stg_hi_d = neg_hi_q ? (WIDTH'(0) - acc_hi_q) : acc_hi_q;
                end else begin
                    stg_lo_d = prod_s[WIDTH-1:0];
                    stg_hi_d = prod_s[W2-1:WIDTH];
                end
                stg_res_d = stg_lo_d;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            mcand_q     <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            is_div_q    <= 1'b0;
            divz_q      <= 1'b0;
            stg_vld_q   <= 1'b0;
            stg_hilo_q  <= 1'b0;
            stg_res_q   <= '0;
            stg_hi_q    <= '0;
            stg_lo_q    <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            mcand_q     <= mcand_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            is_div_q    <= is_div_d;
            divz_q      <= divz_d;
            stg_vld_q   <= stg_vld_d;
            stg_hilo_q  <= stg_hilo_d;
            stg_res_q   <= stg_res_d;
            stg_hi_q    <= stg_hi_d;
            stg_lo_q    <= stg_lo_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and randomized checks of alu_muldiv against an
// arithmetic reference model (plain signed/unsigned SystemVerilog operators).
module tb_alu_muldiv;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] a, b;
    logic [4:0]   shamt;
    logic [W-1:0] result;
    logic         zero;
    logic         out_valid;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;
    logic         pend = 1'b0;
    logic [W-1:0] pend_res = '0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .a(a), .b(b), .shamt(shamt),
        .result(result), .zero(zero), .out_valid(out_valid), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_simple(input logic [3:0] c, input logic [W-1:0] x,
                                                input logic [W-1:0] y, input logic [4:0] s);
        case (c)
            4'b0000:          return x + y;
            4'b0100, 4'b0110: return x - y;
            4'b0101:          return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1000:          return x & y;
            4'b1010:          return x | y;
            4'b1100:          return ~(x | y);
            4'b0010:          return y << s;
            4'b0011:          return y >> s;
            default:          return '0;
        endcase
    endfunction

    task automatic ref_md(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] h, output logic [W-1:0] l);
        longint p;
        int     sx, sy;
        if (c == 4'b1101) begin
            p = longint'($signed(x)) * longint'($signed(y));
            h = p[63:32];
            l = p[31:0];
        end else if (y == '0) begin
            l = '1;
            h = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000;
            h = '0;
        end else begin
            sx = x;
            sy = y;
            l = sx / sy;
            h = sx % sy;
        end
    endtask

    // Checks the output of the op accepted on the previous edge (if any).
    task automatic check_prev(input string tag);
        if (pend) begin
            check({tag, ".ov"}, out_valid, 1);
            check({tag, ".res"}, result, pend_res);
            check({tag, ".zero"}, zero, pend_res == '0);
            check({tag, ".hi"}, hi, mhi);
            check({tag, ".lo"}, lo, mlo);
        end else begin
            check({tag, ".ov0"}, out_valid, 0);
        end
    endtask

    task automatic issue(input string tag, input logic [3:0] c, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [4:0] s, input logic [W-1:0] exp);
        check({tag, ".rdy"}, in_ready, 1);
        in_valid = 1'b1; alu_ctrl = c; a = x; b = y; shamt = s;
        step();
        check_prev(tag);
        pend = 1'b1;
        pend_res = exp;
    endtask

    task automatic idle_tick(input string tag);
        in_valid = 1'b0;
        step();
        check_prev(tag);
        pend = 1'b0;
    endtask

    task automatic run_md(input string tag, input logic [3:0] c, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit busy_offer,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        logic ov_early, rdy_bad;
        ov_early = 1'b0;
        rdy_bad  = 1'b0;
        check({tag, ".rdy"}, in_ready, 1);
        in_valid = 1'b1; alu_ctrl = c; a = x; b = y; shamt = 5'd0;
        step();
        if (busy_offer) begin
            alu_ctrl = 4'b0000; a = 32'd100; b = 32'd23;
        end else begin
            in_valid = 1'b0;
        end
        check({tag, ".busy0"}, in_ready, 0);
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k <= 32 && in_ready !== 1'b0) rdy_bad = 1'b1;
            if (k <= 33 && out_valid !== 1'b0) ov_early = 1'b1;
            if (k == 32) in_valid = 1'b0;
            if (k == 33) check({tag, ".rdyback"}, in_ready, 1);
        end
        check({tag, ".busy"}, rdy_bad, 0);
        check({tag, ".early"}, ov_early, 0);
        check({tag, ".ov"}, out_valid, 1);
        check({tag, ".hi"}, hi, eh);
        check({tag, ".lo"}, lo, el);
        check({tag, ".res"}, result, el);
        check({tag, ".zero"}, zero, el == '0);
        mhi = eh;
        mlo = el;
        step();
        check({tag, ".pulse"}, out_valid, 0);
        check({tag, ".hold"}, result, el);
        pend = 1'b0;
    endtask

    logic [3:0] codes [14] = '{4'b0000, 4'b0100, 4'b0110, 4'b0101, 4'b1000, 4'b1010, 4'b1100,
                               4'b0010, 4'b0011, 4'b1111, 4'b0001, 4'b0111, 4'b1001, 4'b1110};

    initial begin
        logic [3:0]   c;
        logic [W-1:0] x, y, eh, el;
        logic [4:0]   s;
        logic         ov_seen;

        reset_n = 1'b0; in_valid = 1'b0; alu_ctrl = '0; a = '0; b = '0; shamt = '0;
        repeat (2) step();
        check("rst.res", result, 0);
        check("rst.zero", zero, 1);
        check("rst.hi", hi, 0);
        check("rst.lo", lo, 0);
        check("rst.ov", out_valid, 0);
        check("rst.rdy", in_ready, 0);
        reset_n = 1'b1;
        step();

        // Back-to-back simple ops, one accept per cycle.
        issue("b2b.add", 4'b0000, 32'd5, 32'd7, 5'd0, 32'd12);
        issue("b2b.sub", 4'b0100, 32'd3, 32'd3, 5'd0, 32'd0);
        issue("b2b.slt", 4'b0101, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
        issue("b2b.nor", 4'b1100, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
        issue("b2b.srl", 4'b0011, 32'd0, 32'h8000_0000, 5'd31, 32'd1);
        idle_tick("b2b.end");

        // Random simple ops, back to back.
        for (int i = 0; i < 24; i++) begin
            c = codes[$urandom_range(13, 0)];
            x = $urandom; y = $urandom; s = 5'($urandom);
            if (i % 6 == 0) y = x;
            issue("rnd.simple", c, x, y, s, ref_simple(c, x, y, s));
        end
        idle_tick("rnd.end");

        // Directed MULT/DIV corner cases.
        run_md("mult", 4'b1101, 32'hFFFF_FFFD, 32'h4000_0000, 1'b1, 32'hFFFF_FFFF, 32'h4000_0000);
        run_md("div", 4'b1011, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div0", 4'b1011, 32'd9, 32'd0, 1'b0, 32'd9, 32'hFFFF_FFFF);
        run_md("divmin", 4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);

        // Random MULT/DIV.
        for (int i = 0; i < 8; i++) begin
            c = (i % 2 == 0) ? 4'b1101 : 4'b1011;
            x = $urandom;
            y = (i % 4 == 3) ? 32'($urandom_range(100, 1)) : $urandom;
            if (i == 5) y = 32'hFFFF_FFF0;
            ref_md(c, x, y, eh, el);
            run_md("rnd.md", c, x, y, 1'b0, eh, el);
        end

        // Undefined code and NOP leave HI/LO alone.
        issue("undef", 4'b0001, $urandom, $urandom, 5'($urandom), 32'd0);
        issue("nop", 4'b1111, $urandom, $urandom, 5'($urandom), 32'd0);
        idle_tick("nop.end");

        // Reset in the middle of a MULT aborts it.
        in_valid = 1'b1; alu_ctrl = 4'b1101; a = 32'd12345; b = 32'd678;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset_n = 1'b0;
        repeat (2) step();
        check("abort.ov", out_valid, 0);
        check("abort.hi", hi, 0);
        check("abort.lo", lo, 0);
        check("abort.rdy", in_ready, 0);
        reset_n = 1'b1;
        mhi = '0; mlo = '0; pend = 1'b0;
        ov_seen = 1'b0;
        for (int k = 0; k < 36; k++) begin
            step();
            if (out_valid !== 1'b0) ov_seen = 1'b1;
        end
        check("abort.noov", ov_seen, 0);
        x = $urandom; y = $urandom;
        issue("abort.add", 4'b0000, x, y, 5'd0, x + y);
        idle_tick("abort.end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
